eu_q2_pack_encoder: RTL and testbench

- Requant/pack stage at the tail of the EU datapath.
- Takes beats of `LANES` signed accumulators, applies the optional >>1 calibration, and maps each value to the nearest MNISC-Q 2-bit code (00→-3, 01→-1, 10→+1, 11→+3).
- Packs the codes into `BUS_W`-bit output stream words, one code per lane.
- It is the encoder counterpart of the 2-bit decode used on the operand side; its output stream feeds the DDR write stream of CONV3X3, GEMM and ACT_QUANT.

---
 rtl/eu_q2_pack_encoder.sv | 195 +++++++++++++++++++
 tb/tb_eu_q2_pack_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eu_q2_pack_encoder.sv
// Requant/pack stage: optional >>1 calibration, nearest MNISC-Q 2-bit code per lane,
// and packing of BPW beats into one BUS_W-bit output word behind a holding register.
module eu_q2_pack_encoder #(
  parameter  int LANES = 16,
  parameter  int ACC_W = 32,
  parameter  int BUS_W = 128,
  localparam int BPW   = BUS_W / (2 * LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             cfg_flags,
  input  logic [15:0]            cfg_words,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BUS_W-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             err_code,
  output logic [15:0]            clamp_cnt
);

  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CPW = $clog2(LANES + 1);
  localparam logic [7:0] ERR_INVALID_PARAM  = 8'h02;
  localparam logic [7:0] ERR_COUNT_MISMATCH = 8'h05;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         flags_q, flags_d;
  logic [15:0]        words_q, words_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic [BIW-1:0]     beat_idx_q, beat_idx_d;
  logic [BUS_W-1:0]   acc_q, acc_d;
  logic [BUS_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;
  logic [7:0]         err_q, err_d;
  logic [15:0]        clamp_q, clamp_d;

  logic [2*LANES-1:0] beat_codes;
  logic [LANES-1:0]   clamped;
  logic [CPW-1:0]     clamp_pop;
  logic [BUS_W-1:0]   word_fill;
  logic [16:0]        clamp_sum;
  logic               word_end, beat_fire, out_pop;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [ACC_W-1:0] lane_v;
      logic signed [ACC_W-1:0] lane_s;
      assign lane_v = in_data[ACC_W*gi +: ACC_W];
      assign lane_s = flags_q[1] ? (lane_v >>> 1) : lane_v;
      // Decision thresholds sit midway between the code levels -3, -1, +1, +3.
      assign beat_codes[2*gi +: 2] = (lane_s <= -2) ? 2'b00 :
                                     (lane_s == -1) ? 2'b01 :
                                     (lane_s <=  1) ? 2'b10 : 2'b11;
      assign clamped[gi] = (lane_s > 3) || (lane_s < -3);
    end
    for (gi = 0; gi < BPW; gi++) begin : g_field
      assign word_fill[2*LANES*gi +: 2*LANES] =
        (beat_idx_q == BIW'(gi)) ? beat_codes : acc_q[2*LANES*gi +: 2*LANES];
    end
  endgenerate

  always_comb begin
    clamp_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      clamp_pop = clamp_pop + CPW'(clamped[i]);
    end
  end

  assign word_end  = (beat_idx_q == BIW'(BPW - 1)) || in_last;
  assign in_ready  = (state_q == S_RUN) && !(out_valid_q && !out_ready && word_end);
  assign beat_fire = in_valid && in_ready;
  assign out_pop   = out_valid_q && out_ready;
  assign clamp_sum = {1'b0, clamp_q} + 17'(clamp_pop);

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    words_d     = words_q;
    word_cnt_d  = word_cnt_q;
    beat_idx_d  = beat_idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = err_q;
    clamp_d     = clamp_q;

    // Retire the held word first so a new word can reload in the same cycle.
    if (out_pop) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          flags_d    = cfg_flags[2:0];
          words_d    = cfg_words;
          err_d      = 8'h00;
          clamp_d    = 16'h0000;
          word_cnt_d = 16'h0000;
          beat_idx_d = '0;
          acc_d      = '0;
        end
      end
      S_RUN: begin
        if (beat_fire) begin
          clamp_d = clamp_sum[16] ? 16'hFFFF : clamp_sum[15:0];
          if (!flags_q[2] && (|clamped) && (err_q == 8'h00)) begin
            err_d = ERR_INVALID_PARAM;
          end
          if (word_end) begin
            out_valid_d = 1'b1;
            out_data_d  = word_fill;
            out_last_d  = in_last;
            word_cnt_d  = word_cnt_q + 16'd1;
            acc_d       = '0;
            beat_idx_d  = '0;
          end else begin
            acc_d      = word_fill;
            beat_idx_d = beat_idx_q + 1'b1;
          end
          if (in_last) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (out_pop && out_last_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (flags_q[0] && (word_cnt_q != words_q) && (err_q == 8'h00)) begin
            err_d = ERR_COUNT_MISMATCH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flags_q     <= '0;
      words_q     <= '0;
      word_cnt_q  <= '0;
      beat_idx_q  <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      clamp_q     <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      words_q     <= words_d;
      word_cnt_q  <= word_cnt_d;
      beat_idx_q  <= beat_idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      clamp_q     <= clamp_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err_code  = err_q;
  assign clamp_cnt = clamp_q;

endmodule

// File: tb/tb_eu_q2_pack_encoder.sv
// Directed bench for eu_q2_pack_encoder: hand-computed words, flags, counters and handshakes.
module tb_eu_q2_pack_encoder;

  localparam int LANES = 16;
  localparam int ACC_W = 32;
  localparam int BUS_W = 128;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [7:0]             cfg_flags = '0;
  logic [15:0]            cfg_words = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANES*ACC_W-1:0] in_data = '0;
  logic                   in_last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [BUS_W-1:0]       out_data;
  logic                   out_last;
  logic                   busy;
  logic                   done;
  logic [7:0]             err_code;
  logic [15:0]            clamp_cnt;

  int checks = 0;
  int errors = 0;

  logic [BUS_W:0]   words[$];
  logic             stall_prev = 1'b0;
  logic [BUS_W-1:0] hold_data = '0;

  localparam logic [BUS_W-1:0] W_ONES = {BUS_W{1'b1}};
  localparam logic [BUS_W-1:0] W_AAAA = {(BUS_W/32){32'hAAAA_AAAA}};
  localparam logic [BUS_W-1:0] W_5555 = {(BUS_W/32){32'h5555_5555}};
  localparam logic [BUS_W-1:0] W_MIX  = {32'h0000_0000, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h5555_5555};

  eu_q2_pack_encoder #(.LANES(LANES), .ACC_W(ACC_W), .BUS_W(BUS_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_flags(cfg_flags), .cfg_words(cfg_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err_code(err_code), .clamp_cnt(clamp_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Capture every handshaken word and verify the holding register under backpressure.
  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) words.push_back({out_last, out_data});
      if (stall_prev) begin
        check("hold_valid", BUS_W'(out_valid), BUS_W'(1));
        check("hold_data", out_data, hold_data);
      end
      stall_prev <= out_valid && !out_ready;
      hold_data  <= out_data;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic start_op(input logic [7:0] flags, input logic [15:0] nwords);
    words.delete();
    cfg_flags = flags;
    cfg_words = nwords;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic signed [31:0] v, input logic last);
    int t;
    in_valid = 1'b1;
    in_last  = last;
    for (int i = 0; i < LANES; i++) in_data[ACC_W*i +: ACC_W] = v;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("beat_timeout", BUS_W'(0), BUS_W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("done_pulse", BUS_W'(done), BUS_W'(1));
  endtask

  task automatic check_word(input string tag, input int idx, input logic [BUS_W-1:0] exp, input logic exp_last);
    if (idx < words.size()) begin
      check({tag, "_data"}, words[idx][BUS_W-1:0], exp);
      check({tag, "_last"}, BUS_W'(words[idx][BUS_W]), BUS_W'(exp_last));
    end else begin
      check({tag, "_missing"}, BUS_W'(words.size()), BUS_W'(idx + 1));
    end
  endtask

  initial begin
    #2;
    check("rst_out_valid", BUS_W'(out_valid), BUS_W'(0));
    check("rst_busy", BUS_W'(busy), BUS_W'(0));
    check("rst_in_ready", BUS_W'(in_ready), BUS_W'(0));
    check("rst_err", BUS_W'(err_code), BUS_W'(0));
    check("rst_clamp", BUS_W'(clamp_cnt), BUS_W'(0));
    check("rst_out_data", out_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Shift on, lanes=5 -> s=2 -> code 11; not clamped.
    start_op(8'h07, 16'd1);
    for (int b = 0; b < 4; b++) send_beat(32'sd5, b == 3);
    wait_done();
    check("t1_count", BUS_W'(words.size()), BUS_W'(1));
    check_word("t1", 0, W_ONES, 1'b1);
    check("t1_clamp", BUS_W'(clamp_cnt), BUS_W'(0));
    check("t1_err", BUS_W'(err_code), BUS_W'(0));
    @(posedge clk);
    #1;

    // Shift on: -1->-1 (01), 0->0 (10), 2->1 (10), -7->-4 (00, clamped, saturation enabled).
    start_op(8'h07, 16'd1);
    send_beat(-32'sd1, 1'b0);
    send_beat(32'sd0, 1'b0);
    send_beat(32'sd2, 1'b0);
    send_beat(-32'sd7, 1'b1);
    wait_done();
    check_word("t2", 0, W_MIX, 1'b1);
    check("t2_clamp", BUS_W'(clamp_cnt), BUS_W'(16));
    check("t2_err", BUS_W'(err_code), BUS_W'(0));
    @(posedge clk);
    #1;

    // Shift off, saturation disabled, single clamped beat -> partial zero word, error 02.
    start_op(8'h00, 16'd0);
    send_beat(-32'sd4, 1'b1);
    wait_done();
    check("t3_count", BUS_W'(words.size()), BUS_W'(1));
    check_word("t3", 0, '0, 1'b1);
    check("t3_clamp", BUS_W'(clamp_cnt), BUS_W'(16));
    check("t3_err", BUS_W'(err_code), BUS_W'(8'h02));
    @(posedge clk);
    #1;

    // Count check: 2 words emitted against cfg_words=3.
    start_op(8'h05, 16'd3);
    for (int b = 0; b < 8; b++) send_beat(32'sd1, b == 7);
    wait_done();
    check("t4_count", BUS_W'(words.size()), BUS_W'(2));
    check_word("t4w0", 0, W_AAAA, 1'b0);
    check_word("t4w1", 1, W_AAAA, 1'b1);
    check("t4_err", BUS_W'(err_code), BUS_W'(8'h05));
    @(posedge clk);
    #1;

    // Backpressure: out_ready low ~10 cycles; beat 7 must stall behind the held word.
    start_op(8'h00, 16'd2);
    out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++) send_beat((b < 4) ? 32'sd2 : -32'sd1, b == 7);
      end
      begin
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", BUS_W'(in_ready), BUS_W'(0));
        check("bp_out_valid", BUS_W'(out_valid), BUS_W'(1));
        check("bp_out_data", out_data, W_ONES);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_done();
    check("t5_count", BUS_W'(words.size()), BUS_W'(2));
    check_word("t5w0", 0, W_ONES, 1'b0);
    check_word("t5w1", 1, W_5555, 1'b1);
    check("t5_err", BUS_W'(err_code), BUS_W'(0));
    @(posedge clk);
    #1;

    // Reset mid-operation after 2 clamped beats, then a clean 4-beat word.
    start_op(8'h04, 16'd1);
    send_beat(32'sd9, 1'b0);
    send_beat(32'sd9, 1'b0);
    check("t6_pre_clamp", BUS_W'(clamp_cnt), BUS_W'(32));
    rst_n = 1'b0;
    #2;
    check("t6_busy", BUS_W'(busy), BUS_W'(0));
    check("t6_in_ready", BUS_W'(in_ready), BUS_W'(0));
    check("t6_out_valid", BUS_W'(out_valid), BUS_W'(0));
    check("t6_clamp", BUS_W'(clamp_cnt), BUS_W'(0));
    check("t6_err", BUS_W'(err_code), BUS_W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_op(8'h00, 16'd1);
    for (int b = 0; b < 4; b++) send_beat(32'sd0, b == 3);
    wait_done();
    check("t6_count", BUS_W'(words.size()), BUS_W'(1));
    check_word("t6", 0, W_AAAA, 1'b1);
    @(posedge clk);
    #1;
    check("t6_idle", BUS_W'(busy), BUS_W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", BUS_W'(0), BUS_W'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
